// File: rtl/axistream_forwarder_keep.sv
// axistream_forwarder_keep: streams one packet from packetmem onto AXI-Stream with byte-accurate TKEEP
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   TDATA/TKEEP/TVALID/TLAST   AXI-Stream master, driven from the output FIFO head
//   TREADY                     AXI-Stream sink ready
//   forwarder_rd_addr/_rd_en   packetmem read request (word address, strobe)
//   forwarder_rd_data          packetmem read data, valid one cycle after rd_en
//   forwarder_done             one-cycle pulse handing the buffer back after the last beat
//   ready_for_forwarder        packetmem holds a packet for this block
//   len_to_forwarder           packet length in bytes
//   stat_pkts/stat_beats       packet and beat counters, present only with FWD_STATS_EN
//
// Optional feature macro: FWD_STATS_EN
module axistream_forwarder_keep #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int FIFO_DEPTH = 2,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int BSEL = $clog2(BYTES),
    localparam int PLEN_WIDTH = ADDR_WIDTH + BSEL + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] TDATA,
    output logic [BYTES-1:0]      TKEEP,
    output logic                  TVALID,
    output logic                  TLAST,
    input  logic                  TREADY,
    output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
    input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
    output logic                  forwarder_rd_en,
    output logic                  forwarder_done,
    input  logic                  ready_for_forwarder,
    input  logic [PLEN_WIDTH-1:0] len_to_forwarder
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_beats
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   last_addr;
    logic [BYTES-1:0]        last_keep;
    logic                    inflight;
    logic                    tag_last;
    logic [BYTES-1:0]        tag_keep;
    logic [DATA_WIDTH-1:0]   f_data [FIFO_DEPTH];
    logic [BYTES-1:0]        f_keep [FIFO_DEPTH];
    logic                    f_last [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    pop;
    logic                    is_last_rd;
    logic [CW:0]             credit;
    logic [BSEL-1:0]         rem;
    logic [ADDR_WIDTH:0]     nflits;
    logic [BYTES-1:0]        len_keep;

    assign rem      = len_to_forwarder[BSEL-1:0];
    assign nflits   = len_to_forwarder[PLEN_WIDTH-1:BSEL] + (ADDR_WIDTH+1)'(rem != '0);
    assign len_keep = rem == '0 ? '1 : ~({BYTES{1'b1}} << rem);

    assign TVALID = count != '0;
    assign TDATA  = f_data[rd_ptr];
    assign TKEEP  = f_keep[rd_ptr];
    assign TLAST  = f_last[rd_ptr];
    assign pop    = TVALID && TREADY;

    // Entries already held plus the read still in flight, minus the beat leaving now,
    // must leave room for one more word so the FIFO can never overflow.
    assign credit          = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign is_last_rd      = forwarder_rd_addr == last_addr;
    assign forwarder_rd_en = state == READ && ready_for_forwarder && credit < (CW+1)'(FIFO_DEPTH);
    assign forwarder_done  = state == DONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            forwarder_rd_addr <= '0;
            last_addr         <= '0;
            last_keep         <= '0;
            inflight          <= 1'b0;
            tag_last          <= 1'b0;
            tag_keep          <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_data[i] <= '0;
                f_keep[i] <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            // The read tag travels one cycle behind the strobe, aligned with the returning data.
            inflight <= forwarder_rd_en;
            if (forwarder_rd_en) begin
                tag_last <= is_last_rd;
                tag_keep <= is_last_rd ? last_keep : '1;
            end
            if (inflight) begin
                f_data[wr_ptr] <= forwarder_rd_data;
                f_keep[wr_ptr] <= tag_keep;
                f_last[wr_ptr] <= tag_last;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(inflight) - CW'(pop);
            case (state)
                IDLE: if (ready_for_forwarder) begin
                    forwarder_rd_addr <= '0;
                    last_addr         <= ADDR_WIDTH'(nflits - (ADDR_WIDTH+1)'(1));
                    last_keep         <= len_keep;
                    state             <= len_to_forwarder == '0 ? DONE : READ;
                end
                READ: if (forwarder_rd_en) begin
                    forwarder_rd_addr <= is_last_rd ? '0 : forwarder_rd_addr + ADDR_WIDTH'(1);
                    state             <= is_last_rd ? DRAIN : READ;
                end
                DRAIN: state <= pop && TLAST ? DONE : DRAIN;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FWD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkts  <= '0;
            stat_beats <= '0;
        end else begin
            stat_pkts  <= stat_pkts + 32'(forwarder_done);
            stat_beats <= stat_beats + 32'(pop);
        end
    end
`endif
endmodule
